// File: rtl/nonce_collector.sv
// -----------------------------------------------------------------------------
// nonce_collector
//   Gathers golden nonces from SLAVES hashing cores, queues them in a FIFO and
//   feeds serial_core one nonce per serial transaction.
//
//   Ports
//     clk             clock; every input is already in this domain
//     rst_n           asynchronous active-low reset
//     got_ticket_i    per-core ticket level, one rising edge per found nonce
//     golden_nonce_i  per-core nonce, slice i belongs to core i
//     tx_send_o       one-cycle pulse, tx_word_o/tx_slave_o are ready
//     tx_busy_i       serial_core busy flag
//     tx_word_o       nonce being sent (held until the next send)
//     tx_slave_o      index of the core that found tx_word_o
//     new_nonce_o     one-cycle pulse per nonce pushed into the FIFO
//     fifo_count_o    current FIFO occupancy
//     drop_count_o    saturating count of nonces lost to pending overwrites
// -----------------------------------------------------------------------------
module nonce_collector #(
    parameter int SLAVES       = 4,
    parameter int NONCE_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [SLAVES-1:0]                               got_ticket_i,
    input  logic [SLAVES*NONCE_WIDTH-1:0]                   golden_nonce_i,
    output logic                                            tx_send_o,
    input  logic                                            tx_busy_i,
    output logic [NONCE_WIDTH-1:0]                          tx_word_o,
    output logic [((SLAVES > 1) ? $clog2(SLAVES) : 1)-1:0]  tx_slave_o,
    output logic                                            new_nonce_o,
    output logic [$clog2(FIFO_DEPTH):0]                     fifo_count_o,
    output logic [7:0]                                      drop_count_o
);

    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SW + NONCE_WIDTH;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    // capture / arbitration state
    logic [SLAVES-1:0]      prev_q;
    logic [SLAVES-1:0]      pend_v_q, pend_v_d;
    logic [NONCE_WIDTH-1:0] pend_q [SLAVES];
    logic [SW-1:0]          rr_q, rr_d;
    logic [7:0]             drop_q, drop_d;

    // FIFO state, entries are {core index, nonce}
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [CW-1:0]          count_q;

    // sender state
    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic                   tx_send_q;
    logic [NONCE_WIDTH-1:0] tx_word_q;
    logic [SW-1:0]          tx_slave_q;

    logic [SLAVES-1:0]      rise;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    logic [SW-1:0]          win;
    logic [EW-1:0]          head;

    assign rise       = got_ticket_i & ~prev_q;
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_q];
    // The head cannot change between IDLE and SEND (only SEND pops), so the
    // value latched on entry to SEND is the entry popped during SEND.
    assign pop        = (state_q == S_SEND);

    // Round-robin search starting at rr_q; first pending channel wins.
    always_comb begin
        int idx;
        push = 1'b0;
        win  = '0;
        idx  = 0;
        for (int k = 0; k < SLAVES; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= SLAVES) idx = idx - SLAVES;
            if (!push && !fifo_full && pend_v_q[idx]) begin
                push = 1'b1;
                win  = SW'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = (int'(win) == SLAVES - 1) ? '0 : win + 1'b1;
    end

    // A new capture always leaves the slot pending, even on the cycle the
    // old nonce of that channel is granted; only an overwrite of a nonce that
    // is not leaving this cycle counts as a drop.
    always_comb begin
        int ndrop;
        pend_v_d = pend_v_q;
        ndrop    = 0;
        for (int i = 0; i < SLAVES; i++) begin
            if (rise[i]) begin
                pend_v_d[i] = 1'b1;
                if (pend_v_q[i] && !(push && int'(win) == i)) ndrop = ndrop + 1;
            end else if (push && int'(win) == i) begin
                pend_v_d[i] = 1'b0;
            end
        end
        if (int'(drop_q) + ndrop > 255) drop_d = 8'hFF;
        else                            drop_d = drop_q + 8'(ndrop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            pend_v_q <= '0;
            rr_q     <= '0;
            drop_q   <= '0;
        end else begin
            prev_q   <= got_ticket_i;
            pend_v_q <= pend_v_d;
            rr_q     <= rr_d;
            drop_q   <= drop_d;
        end
    end

    // Nonce payloads are qualified by pend_v_q / count_q, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (rise[i]) pend_q[i] <= golden_nonce_i[i*NONCE_WIDTH +: NONCE_WIDTH];
        end
        if (push) mem_q[wr_q] <= {win, pend_q[win]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            tx_send_q  <= 1'b0;
            tx_word_q  <= '0;
            tx_slave_q <= '0;
        end else begin
            tx_send_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty && !tx_busy_i) begin
                        state_q    <= S_SEND;
                        tx_send_q  <= 1'b1;
                        tx_word_q  <= head[NONCE_WIDTH-1:0];
                        tx_slave_q <= head[EW-1 -: SW];
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_BUSY;
                    timer_q <= '0;
                end
                S_WAIT_BUSY: begin
                    // A send that never raises tx_busy is abandoned, not retried.
                    if (tx_busy_i)                              state_q <= S_WAIT_DONE;
                    else if (timer_q == TW'(BUSY_TIMEOUT - 1)) state_q <= S_IDLE;
                    else                                        timer_q <= timer_q + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_send_o    = tx_send_q;
    assign tx_word_o    = tx_word_q;
    assign tx_slave_o   = tx_slave_q;
    assign new_nonce_o  = push;
    assign fifo_count_o = count_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_nonce_collector.sv
module tb_nonce_collector;

    localparam int SLAVES = 4;
    localparam int NW     = 32;
    localparam int BT     = 1024;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     got;
    logic [127:0]   golden;
    logic           tx_busy;
    logic           tx_send_o;
    logic [31:0]    tx_word_o;
    logic [1:0]     tx_slave_o;
    logic           new_nonce_o;
    logic [3:0]     fifo_count_o;
    logic [7:0]     drop_count_o;

    always #5 clk = ~clk;

    nonce_collector #(
        .SLAVES(SLAVES), .NONCE_WIDTH(NW), .FIFO_DEPTH(8), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .got_ticket_i(got), .golden_nonce_i(golden),
        .tx_send_o(tx_send_o), .tx_busy_i(tx_busy),
        .tx_word_o(tx_word_o), .tx_slave_o(tx_slave_o),
        .new_nonce_o(new_nonce_o), .fifo_count_o(fifo_count_o),
        .drop_count_o(drop_count_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nn_cnt = 0;
    int send_cnt = 0;
    int last_send = -1;
    int tlast = -1;
    bit tchk = 0;
    int busy_mode = 0;   // 0: serial model, 1: held busy, 2: tied low
    int busy_dly = 0;
    int busy_hold = 0;
    int mrr = 0;         // reference round-robin start
    logic [33:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; observes outputs 1 ns after the edge and runs the serial model.
    task automatic tick();
        logic [33:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (new_nonce_o) nn_cnt++;
        if (tx_send_o) begin
            send_cnt++;
            chk("send_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_word", 64'(tx_word_o), 64'(e[31:0]));
                chk("tx_slave", 64'(tx_slave_o), 64'(e[33:32]));
            end
            if (last_send >= 0) chk("send_spacing", 64'(cyc - last_send >= 4), 64'd1);
            if (tchk && tlast >= 0)
                chk("timeout_gap", 64'((cyc - tlast >= BT + 1) && (cyc - tlast <= BT + 3)), 64'd1);
            last_send = cyc;
            tlast = cyc;
        end
        if (busy_mode == 1) tx_busy = 1'b1;
        else if (busy_mode == 2) tx_busy = 1'b0;
        else if (tx_send_o) busy_dly = 2;
        else if (busy_dly > 0) begin
            busy_dly--;
            if (busy_dly == 0) begin tx_busy = 1'b1; busy_hold = 20; end
        end else if (busy_hold > 0) begin
            busy_hold--;
            if (busy_hold == 0) tx_busy = 1'b0;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        mrr = 0;
        busy_dly = 0;
        busy_hold = 0;
        tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        got = '0;
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (30) tick();
    endtask

    initial begin
        int n0, s0;
        logic [3:0]  mask;
        logic [31:0] vals [4];
        logic [31:0] base, x, old;
        logic [1:0]  cs;
        int last;

        rst_n = 1'b0;
        got = '0;
        golden = '0;
        tx_busy = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_tx_send", 64'(tx_send_o), 64'd0);
        chk("rst_tx_word", 64'(tx_word_o), 64'd0);
        chk("rst_tx_slave", 64'(tx_slave_o), 64'd0);
        chk("rst_new_nonce", 64'(new_nonce_o), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count_o), 64'd0);
        chk("rst_drop", 64'(drop_count_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------------- single core, level held 4 cycles ----------------
        n0 = nn_cnt; s0 = send_cnt;
        golden[31:0] = 32'hDEADBEEF;
        got = 4'b0001;
        exp_q.push_back({2'd0, 32'hDEADBEEF});
        tick();
        chk("lat_new_nonce", 64'(new_nonce_o), 64'd1);
        chk("lat_count_early", 64'(fifo_count_o), 64'd0);
        tick();
        chk("lat_count", 64'(fifo_count_o), 64'd1);
        tick(); tick();
        got = '0;
        repeat (60) tick();
        chk("single_new_nonce", 64'(nn_cnt - n0), 64'd1);
        chk("single_sends", 64'(send_cnt - s0), 64'd1);
        chk("single_hold_word", 64'(tx_word_o), 64'hDEADBEEF);
        chk("single_hold_slave", 64'(tx_slave_o), 64'd0);
        chk("single_queue", 64'(exp_q.size()), 64'd0);

        // ---------------- simultaneous bursts from rr=0 ----------------
        do_reset();
        s0 = send_cnt;
        for (int c = 0; c < 4; c++) begin
            golden[c*32 +: 32] = 32'h10 + 32'(c);
            cs = 2'(c);
            exp_q.push_back({cs, 32'h10 + 32'(c)});
        end
        got = 4'hF;
        tick();
        got = '0;
        for (int k = 0; k < 4; k++) begin
            chk("burst_new_nonce", 64'(new_nonce_o), 64'd1);
            tick();
        end
        chk("burst_new_nonce_end", 64'(new_nonce_o), 64'd0);
        golden[31:0] = 32'h20;
        golden[95:64] = 32'h22;
        exp_q.push_back({2'd0, 32'h20});
        exp_q.push_back({2'd2, 32'h22});
        got = 4'b0101;
        tick();
        got = '0;
        wait_drain(400);
        chk("burst_sends", 64'(send_cnt - s0), 64'd6);
        mrr = 3;

        // ---------------- random bursts vs reference ordering ----------------
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            last = mrr;
            for (int k = 0; k < 4; k++) begin
                vals[k] = $urandom;
                golden[k*32 +: 32] = vals[k];
            end
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (mrr + k) % 4;
                if (mask[c]) begin
                    cs = 2'(c);
                    exp_q.push_back({cs, vals[c]});
                    last = c;
                end
            end
            mrr = (last + 1) % 4;
            got = mask;
            tick();
            got = '0;
            wait_drain(400);
        end
        chk("rand_drop", 64'(drop_count_o), 64'd0);

        // ---------------- overflow with tx_busy held ----------------
        do_reset();
        s0 = send_cnt;
        busy_mode = 1;
        tick();
        base = $urandom & 32'hFFFF_FF00;
        for (int i = 0; i < 12; i++) begin
            golden[31:0] = base + 32'(i);
            if (i < 8) exp_q.push_back({2'd0, base + 32'(i)});
            got = 4'b0001;
            tick();
            got = '0;
            tick();
        end
        exp_q.push_back({2'd0, base + 32'd11});
        repeat (3) tick();
        chk("ovf_fifo_count", 64'(fifo_count_o), 64'd8);
        chk("ovf_drop", 64'(drop_count_o), 64'd3);
        chk("ovf_no_send", 64'(send_cnt - s0), 64'd0);
        busy_mode = 0;
        tx_busy = 1'b0;
        wait_drain(800);
        chk("ovf_sends", 64'(send_cnt - s0), 64'd9);
        chk("ovf_drop_after", 64'(drop_count_o), 64'd3);

        // ---------------- same-cycle grant and capture ----------------
        do_reset();
        n0 = nn_cnt;
        x = $urandom;
        old = $urandom;
        golden[31:0] = x;
        golden[63:32] = old;
        exp_q.push_back({2'd0, x});
        exp_q.push_back({2'd1, old});
        exp_q.push_back({2'd1, 32'hAA});
        got = 4'b0011;
        tick();
        got = '0;
        tick();
        golden[63:32] = 32'hAA;
        got = 4'b0010;
        tick();
        got = '0;
        wait_drain(300);
        chk("samecyc_drop", 64'(drop_count_o), 64'd0);
        chk("samecyc_new_nonce", 64'(nn_cnt - n0), 64'd3);

        // ---------------- busy timeout, tx_busy tied low ----------------
        busy_mode = 2;
        tx_busy = 1'b0;
        tchk = 1;
        tlast = -1;
        s0 = send_cnt;
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            golden[127:96] = vals[i];
            exp_q.push_back({2'd3, vals[i]});
            got = 4'b1000;
            tick();
            got = '0;
            tick();
        end
        wait_drain(4000);
        chk("timeout_sends", 64'(send_cnt - s0), 64'd3);
        tchk = 0;
        repeat (1100) tick();

        // ---------------- reset during WAIT_DONE ----------------
        busy_mode = 0;
        tx_busy = 1'b0;
        s0 = send_cnt;
        base = $urandom;
        for (int i = 0; i < 6; i++) begin
            golden[31:0] = base + 32'(i);
            exp_q.push_back({2'd0, base + 32'(i)});
            got = 4'b0001;
            tick();
            got = '0;
            tick();
        end
        tick(); tick();
        chk("mid_fifo_count", 64'(fifo_count_o), 64'd5);
        chk("mid_sends", 64'(send_cnt - s0), 64'd1);
        chk("mid_busy_model", 64'(tx_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_send", 64'(tx_send_o), 64'd0);
        chk("arst_tx_word", 64'(tx_word_o), 64'd0);
        chk("arst_tx_slave", 64'(tx_slave_o), 64'd0);
        chk("arst_new_nonce", 64'(new_nonce_o), 64'd0);
        chk("arst_fifo_count", 64'(fifo_count_o), 64'd0);
        chk("arst_drop", 64'(drop_count_o), 64'd0);
        clear_model();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_hold_tx_send", 64'(tx_send_o), 64'd0);
        end
        rst_n = 1'b1;
        n0 = nn_cnt;
        s0 = send_cnt;
        repeat (100) tick();
        chk("post_rst_no_send", 64'(send_cnt - s0), 64'd0);
        chk("post_rst_no_push", 64'(nn_cnt - n0), 64'd0);
        chk("post_rst_fifo", 64'(fifo_count_o), 64'd0);
        x = $urandom;
        golden[95:64] = x;
        exp_q.push_back({2'd2, x});
        got = 4'b0100;
        tick();
        got = '0;
        wait_drain(200);
        chk("post_rst_send", 64'(send_cnt - s0), 64'd1);
        chk("post_rst_slave", 64'(tx_slave_o), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
